// File: rtl/velocity_cell_reader_pkg.sv
// velocity_cell_reader_pkg: shared widths, defaults and FSM encoding for the velocity cell reader.
package velocity_cell_reader_pkg;
   localparam int DEF_DATA_WIDTH   = 96;
   localparam int DEF_ADDR_WIDTH   = 8;
   localparam int DEF_PARTICLE_NUM = 220;
   localparam int DEF_READ_LATENCY = 1;
   typedef enum logic [1:0] {IDLE, WAIT_CNT, STREAM, DRAIN} state_e;
endpackage

// File: rtl/velocity_rd_fifo.sv
// velocity_rd_fifo: small circular FIFO catching RAM return words tagged with {id,last}.
module velocity_rd_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 105
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             head_o,
   output logic [$clog2(DEPTH+1)-1:0]   occ_o,
   output logic                         empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] buf_q [DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [OW-1:0]    occ_q;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
      end else begin
         if (push_i) begin
            buf_q[wr_q] <= push_data_i;
            wr_q        <= inc(wr_q);
         end
         if (pop_i) rd_q <= inc(rd_q);
         occ_q <= occ_q + OW'(push_i) - OW'(pop_i);
      end
   end
   assign head_o  = buf_q[rd_q];
   assign occ_o   = occ_q;
   assign empty_o = (occ_q == '0);
endmodule

// File: rtl/velocity_cell_reader.sv
// velocity_cell_reader: reads a cell's particle count, then streams records 1..N from RAM
// onto a valid/ready interface, using a credit scheme sized to the RAM read latency.
module velocity_cell_reader
   import velocity_cell_reader_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int PARTICLE_NUM = DEF_PARTICLE_NUM,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  count_err,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_rden,
   output logic                  mem_wren,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_vel,
   output logic [ADDR_WIDTH-1:0] out_id,
   output logic                  out_last
);
   localparam int FIFO_DEPTH = READ_LATENCY + 1;
   localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam int OW = $clog2(FIFO_DEPTH + 1);
   localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
   state_e                state_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, cnt_q, addr_q;
   logic [WW-1:0]         wait_q;
   logic                  done_q, err_q;
   logic                  trk_vld_q  [READ_LATENCY];
   logic [ADDR_WIDTH-1:0] trk_id_q   [READ_LATENCY];
   logic                  trk_last_q [READ_LATENCY];
   logic [OW-1:0]         occ, inflight;
   logic [OW:0]           tokens;
   logic [FW-1:0]         head;
   logic                  empty, pop, idle_issue, str_issue;
   logic [ADDR_WIDTH-1:0] cnt_raw, cnt_clamp;
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + OW'(trk_vld_q[i]);
   end
   // A slot freed by this cycle's pop is already available for the next read.
   assign tokens      = (OW+1)'(occ) + (OW+1)'(inflight);
   assign pop         = out_valid && out_ready;
   assign idle_issue  = (state_q == IDLE) && start;
   assign str_issue   = (state_q == STREAM) && (tokens < (OW+1)'(FIFO_DEPTH) + (OW+1)'(pop));
   assign mem_rden    = idle_issue || str_issue;
   assign mem_address = idle_issue ? '0 : str_issue ? rd_ptr_q : addr_q;
   assign mem_wren    = 1'b0;
   assign mem_data    = '0;
   assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
   assign cnt_clamp   = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         wait_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         addr_q <= mem_address;
         case (state_q)
            IDLE: if (start) begin
               state_q <= WAIT_CNT;
               wait_q  <= '0;
               err_q   <= 1'b0;
            end
            WAIT_CNT: if (wait_q == WW'(READ_LATENCY - 1)) begin
               err_q    <= cnt_raw > MAX_CNT;
               cnt_q    <= cnt_clamp;
               rd_ptr_q <= ADDR_WIDTH'(1);
               done_q   <= (cnt_clamp == '0);
               state_q  <= (cnt_clamp == '0) ? IDLE : STREAM;
            end else wait_q <= wait_q + 1'b1;
            STREAM: if (str_issue) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
               if (rd_ptr_q == cnt_q) state_q <= DRAIN;
            end
            DRAIN: if (tokens == (OW+1)'(pop)) begin
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            trk_vld_q[i]  <= 1'b0;
            trk_id_q[i]   <= '0;
            trk_last_q[i] <= 1'b0;
         end
      end else begin
         trk_vld_q[0]  <= str_issue;
         trk_id_q[0]   <= rd_ptr_q;
         trk_last_q[0] <= (rd_ptr_q == cnt_q);
         for (int i = 1; i < READ_LATENCY; i++) begin
            trk_vld_q[i]  <= trk_vld_q[i-1];
            trk_id_q[i]   <= trk_id_q[i-1];
            trk_last_q[i] <= trk_last_q[i-1];
         end
      end
   end
   velocity_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (trk_vld_q[READ_LATENCY-1]),
      .push_data_i ({mem_q, trk_id_q[READ_LATENCY-1], trk_last_q[READ_LATENCY-1]}),
      .pop_i       (pop),
      .head_o      (head),
      .occ_o       (occ),
      .empty_o     (empty)
   );
   assign out_valid = !empty;
   assign out_vel   = out_valid ? head[FW-1 -: DATA_WIDTH] : '0;
   assign out_id    = out_valid ? head[ADDR_WIDTH:1] : '0;
   assign out_last  = out_valid && head[0];
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign count_err = err_q;
endmodule

// File: tb/tb_velocity_cell_reader.sv
// tb_velocity_cell_reader: runs READ_LATENCY=1 and =2 readers side by side against a shared
// RAM image and checks their streams against the records the count word says should appear.
module tb_velocity_cell_reader;
   localparam int DW = 96;
   localparam int AW = 8;
   localparam int PN = 220;
   typedef struct packed {logic [AW-1:0] id; logic [DW-1:0] vel; logic last;} rec_t;
   typedef struct {int cnt; int mode; bit restart; int exp_n; bit exp_err;} vec_t;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b0;
   logic          busy_w [2], done_w [2], err_w [2], rden_w [2], wren_w [2], valid_w [2], last_w [2];
   logic [AW-1:0] addr_w [2], id_w [2];
   logic [DW-1:0] data_w [2], vel_w [2], q_w [2];
   logic [DW-1:0] mem [256];
   logic [DW-1:0] q2_pipe;
   int   cyc = 0, t0 = 0, n_chk = 0, n_pass = 0;
   bit   run_on = 1'b0;
   int   first_k [2], done_k [2], last_hs [2], done_cnt [2], rden_cnt [2], next_addr [2], max_occ [2];
   logic busy1 [2], stall_q [2];
   rec_t prev_r [2];
   rec_t got0 [$], got1 [$];
   vec_t tbl [11];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // RAM returns mem[addr] one (u1) or two (u2) cycles after the address is presented.
   always @(posedge clk) begin
      q_w[0]  <= mem[addr_w[0]];
      q2_pipe <= mem[addr_w[1]];
      q_w[1]  <= q2_pipe;
   end
   velocity_cell_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .start(start), .busy(busy_w[0]), .done(done_w[0]), .count_err(err_w[0]),
      .mem_address(addr_w[0]), .mem_rden(rden_w[0]), .mem_wren(wren_w[0]), .mem_data(data_w[0]),
      .mem_q(q_w[0]), .out_valid(valid_w[0]), .out_ready(out_ready), .out_vel(vel_w[0]),
      .out_id(id_w[0]), .out_last(last_w[0]));
   velocity_cell_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u2 (
      .clk(clk), .rst(rst), .start(start), .busy(busy_w[1]), .done(done_w[1]), .count_err(err_w[1]),
      .mem_address(addr_w[1]), .mem_rden(rden_w[1]), .mem_wren(wren_w[1]), .mem_data(data_w[1]),
      .mem_q(q_w[1]), .out_valid(valid_w[1]), .out_ready(out_ready), .out_vel(vel_w[1]),
      .out_id(id_w[1]), .out_last(last_w[1]));
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   function automatic logic rdy(input int mode, input int k);
      logic [5:0] pat;
      pat = 6'b101001;
      case (mode)
         0: return 1'b1;
         1: return pat[k % 6];
         2: return ($urandom % 4) != 0;
         default: return ($urandom % 2) != 0;
      endcase
   endfunction
   task automatic clear_mon();
      got0.delete();
      got1.delete();
      for (int d = 0; d < 2; d++) begin
         first_k[d] = -1; done_k[d] = -1; last_hs[d] = -1; done_cnt[d] = 0;
         rden_cnt[d] = 0; next_addr[d] = 0; max_occ[d] = 0; busy1[d] = 1'b0; stall_q[d] = 1'b0;
      end
   endtask
   always @(negedge clk) if (run_on) begin : mon
      int   k, occ;
      rec_t r;
      k = cyc - t0;
      for (int d = 0; d < 2; d++) begin
         r = '{id: id_w[d], vel: vel_w[d], last: last_w[d]};
         if (k == 1) busy1[d] = busy_w[d];
         if (valid_w[d] && first_k[d] < 0) first_k[d] = k;
         if (stall_q[d]) chk($sformatf("rl%0d stall hold", d + 1), {valid_w[d], r}, {1'b1, prev_r[d]});
         stall_q[d] = valid_w[d] && !out_ready;
         prev_r[d]  = r;
         if (valid_w[d] && out_ready) begin
            if (d == 0) got0.push_back(r); else got1.push_back(r);
            last_hs[d] = k;
         end
         if (done_w[d]) begin
            done_cnt[d]++;
            done_k[d] = k;
            chk($sformatf("rl%0d busy with done", d + 1), busy_w[d], 0);
         end
         if (rden_w[d]) begin
            chk($sformatf("rl%0d read addr", d + 1), addr_w[d], next_addr[d]);
            next_addr[d]++;
            rden_cnt[d]++;
         end
         occ = (d == 0) ? int'(u1.u_fifo.occ_o) : int'(u2.u_fifo.occ_o);
         if (occ > max_occ[d]) max_occ[d] = occ;
      end
   end
   task automatic load_mem(input int cnt);
      logic [DW-1:0] w;
      w = {$urandom, $urandom, $urandom};
      w[AW-1:0] = AW'(cnt);
      mem[0] = w;
      for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
   endtask
   task automatic run(input int row, input vec_t v);
      int k;
      load_mem(v.cnt);
      clear_mon();
      t0 = cyc;
      run_on = 1'b1;
      for (k = 0; k < 4000 && !(done_cnt[0] > 0 && done_cnt[1] > 0); k++) begin
         out_ready = rdy(v.mode, k);
         start = (k == 0) || (v.restart && (k == 3 || k == 8));
         @(posedge clk); #1;
      end
      start = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      run_on = 1'b0;
      for (int d = 0; d < 2; d++) begin
         int    rl = d + 1;
         int    sz = (d == 0) ? got0.size() : got1.size();
         string p  = $sformatf("row%0d rl%0d", row, rl);
         rec_t  r, e;
         chk({p, " record count"}, sz, v.exp_n);
         for (int i = 0; i < sz && i < v.exp_n; i++) begin
            r = (d == 0) ? got0[i] : got1[i];
            e = '{id: AW'(i + 1), vel: mem[i + 1], last: (i + 1 == v.exp_n)};
            chk($sformatf("%s rec%0d", p, i + 1), r, e);
         end
         chk({p, " done pulses"}, done_cnt[d], 1);
         chk({p, " count_err"}, err_w[d], v.exp_err);
         chk({p, " reads issued"}, rden_cnt[d], v.exp_n + 1);
         chk({p, " busy after start"}, busy1[d], 1);
         chk({p, " fifo occ bound"}, max_occ[d] <= rl + 1, 1);
         if (v.exp_n == 0) begin
            chk({p, " no valid"}, first_k[d], -1);
            chk({p, " empty done cycle"}, done_k[d], rl + 1);
         end else begin
            chk({p, " first valid cycle"}, first_k[d], 2 * rl + 2);
            chk({p, " done after last"}, done_k[d], last_hs[d] + 1);
            if (v.mode == 0) chk({p, " done cycle"}, done_k[d], 2 * rl + 2 + v.exp_n);
         end
      end
   endtask
   task automatic chk_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s rl%0d ctrl zero", tag, d + 1),
             {busy_w[d], done_w[d], err_w[d], rden_w[d], wren_w[d], addr_w[d], valid_w[d], id_w[d], last_w[d]}, 0);
         chk($sformatf("%s rl%0d data zero", tag, d + 1), {vel_w[d], data_w[d]}, 0);
      end
   endtask
   initial begin
      int k, c;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b1;
      tbl[0] = '{3, 0, 1'b0, 3, 1'b0};
      tbl[1] = '{0, 0, 1'b0, 0, 1'b0};
      tbl[2] = '{5, 1, 1'b0, 5, 1'b0};
      tbl[3] = '{250, 0, 1'b0, 219, 1'b1};
      tbl[4] = '{6, 0, 1'b1, 6, 1'b0};
      tbl[5] = '{1, 1, 1'b0, 1, 1'b0};
      tbl[6] = '{219, 2, 1'b0, 219, 1'b0};
      tbl[7] = '{220, 3, 1'b0, 219, 1'b1};
      for (int i = 8; i < 11; i++) begin
         c = $urandom_range(0, 40);
         tbl[i] = '{c, $urandom_range(0, 3), 1'b0, c, 1'b0};
      end
      for (int i = 0; i < 11; i++) run(i, tbl[i]);
      load_mem(12);
      clear_mon();
      t0 = cyc;
      run_on = 1'b1;
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (k = 0; k < 100 && !(got0.size() >= 2 && got1.size() >= 2); k++) begin
         @(posedge clk); #1;
      end
      chk("mid-stream progress", got0.size() >= 2 && got1.size() >= 2, 1);
      chk("still streaming", busy_w[0] && busy_w[1], 1);
      run_on = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_zero("mid reset");
      rst = 1'b1;
      run(11, '{2, 0, 1'b0, 2, 1'b0});
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
